// File: rtl/bus_datapath_pkg.sv
// Shared codes for the bus datapath: ALU ops, bus source/destination
// selectors and memory FSM state encodings.
package bus_datapath_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam logic [3:0] SRC_ZERO = 4'd0;
  localparam logic [3:0] SRC_ALU  = 4'd1;
  localparam logic [3:0] SRC_PC   = 4'd2;
  localparam logic [3:0] SRC_MDR  = 4'd3;
  localparam logic [3:0] SRC_REG0 = 4'd4;

  localparam logic [3:0] DST_NONE = 4'd0;
  localparam logic [3:0] DST_A    = 4'd1;
  localparam logic [3:0] DST_B    = 4'd2;
  localparam logic [3:0] DST_PC   = 4'd3;
  localparam logic [3:0] DST_MAR  = 4'd4;
  localparam logic [3:0] DST_MDR  = 4'd5;
  localparam logic [3:0] DST_REG0 = 4'd6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/bus_datapath_alu.sv
// alu_core: combinational ALU, result truncated to WIDTH plus carry.
// Ports: a_i, b_i operands; op_i opcode; res_o result; carry_o carry.
module alu_core
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = '0;
    res_o   = '0;
    carry_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_SUB: begin
        // A + ~B + 1 so carry means "no borrow"
        sum     = {1'b0, a_i} + {1'b0, ~b_i}
                + {{WIDTH{1'b0}}, 1'b1};
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_NOT: res_o = ~a_i;
      OP_SHL: begin
        res_o   = {a_i[WIDTH-2:0], 1'b0};
        carry_o = a_i[WIDTH-1];
      end
      OP_SHR: begin
        res_o   = {1'b0, a_i[WIDTH-1:1]};
        carry_o = a_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_datapath.sv
// bus_datapath: single-bus register datapath with ALU, PC and memory FSM.
// Ports: src/dst selects drive the bus, ALU/PC controls, memory handshake.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 4,
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              src_sel,
  input  logic [3:0]              dst_sel,
  input  logic [2:0]              alu_op,
  input  logic                    alu_lat,
  input  logic                    pc_inc,
  input  logic                    mem_rd,
  input  logic                    mem_wr,
  input  logic [NPORTS*WIDTH-1:0] port_in,
  output logic [NPORTS*WIDTH-1:0] port_out,
  output logic [WIDTH-1:0]        bus,
  output logic                    zero,
  output logic                    carry,
  output logic [WIDTH-1:0]        mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] aout_q, aout_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic [WIDTH-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] pout_q [NPORTS];
  logic [WIDTH-1:0] pout_d [NPORTS];
  logic [1:0]       st_q, st_d;
  logic             we_q, we_d, err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] bus_w, alu_res;
  logic             alu_c, busy_w;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (alu_op),
    .res_o  (alu_res),
    .carry_o(alu_c)
  );

  assign busy_w = (st_q == ST_ACCESS);

  always_comb begin
    bus_w = '0;
    unique case (src_sel)
      SRC_ALU: bus_w = aout_q;
      SRC_PC:  bus_w = pc_q;
      SRC_MDR: bus_w = mdr_q;
      default: ;
    endcase
    for (int i = 0; i < NREGS; i++)
      if (int'(src_sel) == int'(SRC_REG0) + i)
        bus_w = regs_q[i];
    for (int i = 0; i < NPORTS; i++)
      if (int'(src_sel) == int'(SRC_REG0) + NREGS + i)
        bus_w = port_in[i*WIDTH +: WIDTH];
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    aout_d  = aout_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    regs_d  = regs_q;
    pout_d  = pout_q;
    if (pc_inc)
      pc_d = pc_q + WIDTH'(1);
    unique case (dst_sel)
      DST_A:   a_d  = bus_w;
      DST_B:   b_d  = bus_w;
      DST_PC:  pc_d = bus_w;
      DST_MAR: if (!busy_w) mar_d = bus_w;
      DST_MDR: if (!busy_w) mdr_d = bus_w;
      default: ;
    endcase
    for (int i = 0; i < NREGS; i++)
      if (int'(dst_sel) == int'(DST_REG0) + i)
        regs_d[i] = bus_w;
    for (int i = 0; i < NPORTS; i++)
      if (int'(dst_sel) == int'(DST_REG0) + NREGS + i)
        pout_d[i] = bus_w;
    if (alu_lat) begin
      aout_d  = alu_res;
      zero_d  = (alu_res == '0);
      carry_d = alu_c;
    end
    if (busy_w && mem_ack && !we_q)
      mdr_d = mem_rdata;
  end

  always_comb begin
    st_d  = st_q;
    we_d  = we_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (mem_rd && mem_wr) begin
          err_d = 1'b1;
        end else if (mem_rd || mem_wr) begin
          st_d  = ST_ACCESS;
          we_d  = mem_wr;
          cnt_d = '0;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          st_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          st_d  = ST_IDLE;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      aout_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      pc_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      for (int i = 0; i < NPORTS; i++)
        pout_q[i] <= '0;
      st_q    <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      aout_q  <= aout_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      regs_q  <= regs_d;
      pout_q  <= pout_d;
      st_q    <= st_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    port_out = '0;
    for (int i = 0; i < NPORTS; i++)
      port_out[i*WIDTH +: WIDTH] = pout_q[i];
  end

  assign bus       = bus_w;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_req   = busy_w;
  assign mem_we    = busy_w && we_q;
  assign busy      = busy_w;
  assign done      = (st_q == ST_DONE);
  assign mem_err   = err_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: stimulus queues expectations,
// a negedge monitor pops and compares them and memory completion events.
module tb_bus_datapath;

  localparam int W  = 16;
  localparam int NR = 4;
  localparam int NP = 2;

  localparam int K_BUS   = 0;
  localparam int K_ZERO  = 1;
  localparam int K_CARRY = 2;
  localparam int K_ADDR  = 3;
  localparam int K_WDATA = 4;
  localparam int K_BUSY  = 5;
  localparam int K_REQ   = 6;
  localparam int K_WE    = 7;
  localparam int K_DONE  = 8;
  localparam int K_ERR   = 9;
  localparam int K_POUT0 = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    src_sel = '0, dst_sel = '0;
  logic [2:0]    alu_op = '0;
  logic          alu_lat = 1'b0, pc_inc = 1'b0;
  logic          mem_rd = 1'b0, mem_wr = 1'b0, mem_ack = 1'b0;
  logic [NP*W-1:0] port_in = '0;
  logic [NP*W-1:0] port_out;
  logic [W-1:0]  bus, mem_addr, mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          zero, carry, mem_req, mem_we;
  logic          busy, done, mem_err;

  bus_datapath #(
    .WIDTH(W), .NREGS(NR), .NPORTS(NP), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .src_sel(src_sel), .dst_sel(dst_sel),
    .alu_op(alu_op), .alu_lat(alu_lat), .pc_inc(pc_inc),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .port_in(port_in), .port_out(port_out),
    .bus(bus), .zero(zero), .carry(carry),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .done(done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    int           k;
    logic [W-1:0] exp;
  } chk_t;

  typedef struct {
    string        nm;
    logic         err;
    logic [W-1:0] mdr;
  } ev_t;

  chk_t cq[$];
  ev_t  evq[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic fin = 1'b0;
  logic fin_done = 1'b0;

  function automatic logic [W-1:0] probe(int k);
    case (k)
      K_BUS:   return bus;
      K_ZERO:  return {15'b0, zero};
      K_CARRY: return {15'b0, carry};
      K_ADDR:  return mem_addr;
      K_WDATA: return mem_wdata;
      K_BUSY:  return {15'b0, busy};
      K_REQ:   return {15'b0, mem_req};
      K_WE:    return {15'b0, mem_we};
      K_DONE:  return {15'b0, done};
      K_ERR:   return {15'b0, mem_err};
      K_POUT0: return port_out[W-1:0];
      default: return 'x;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    chk_t c;
    ev_t  e;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      n_chk++;
      if (probe(c.k) !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h",
                 c.nm, probe(c.k), c.exp);
      end
    end
    if (done || mem_err) begin
      n_chk++;
      if (evq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got done=%b err=%b expected none",
                 done, mem_err);
      end else begin
        e = evq.pop_front();
        if (mem_err !== e.err || done !== !e.err
            || mem_wdata !== e.mdr) begin
          n_err++;
          $display("FAIL %s: got err=%b done=%b mdr=%h expected err=%b done=%b mdr=%h",
                   e.nm, mem_err, done, mem_wdata,
                   e.err, !e.err, e.mdr);
        end
      end
    end
    if (fin && !fin_done) begin
      fin_done <= 1'b1;
      n_chk++;
      if (evq.size() != 0) begin
        n_err++;
        $display("FAIL missing_events: got %0d pending expected 0",
                 evq.size());
      end
    end
  end

  task automatic cyc(input logic [3:0] s, input logic [3:0] d,
                     input logic [2:0] op = 3'd0,
                     input logic lat = 1'b0, input logic inc = 1'b0,
                     input logic rd = 1'b0, input logic wr = 1'b0,
                     input logic ack = 1'b0);
    @(posedge clk);
    #1;
    src_sel = s;
    dst_sel = d;
    alu_op  = op;
    alu_lat = lat;
    pc_inc  = inc;
    mem_rd  = rd;
    mem_wr  = wr;
    mem_ack = ack;
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [W-1:0] e);
    cq.push_back('{nm, k, e});
  endtask

  task automatic ev(input string nm, input logic err,
                    input logic [W-1:0] mdr);
    evq.push_back('{nm, err, mdr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    port_in = {16'hFFFD, 16'h0005};
    cyc(1, 0);
    chk("rst_aluout", K_BUS, 16'h0000);
    chk("rst_zero", K_ZERO, 0);
    chk("rst_carry", K_CARRY, 0);
    chk("rst_mar", K_ADDR, 0);
    chk("rst_mdr", K_WDATA, 0);
    chk("rst_busy", K_BUSY, 0);
    chk("rst_pout", K_POUT0, 0);
    cyc(2, 0);
    chk("rst_pc", K_BUS, 0);
    rst = 1'b1;

    cyc(8, 6);
    cyc(9, 7);
    cyc(4, 1);
    chk("bus_reg0", K_BUS, 16'h0005);
    cyc(5, 2);
    chk("bus_reg1", K_BUS, 16'hFFFD);
    cyc(0, 0, 3'd0, 1);
    cyc(1, 0);
    chk("add_res", K_BUS, 16'h0002);
    chk("add_carry", K_CARRY, 1);
    chk("add_zero", K_ZERO, 0);

    port_in = {16'h1234, 16'h8001};
    cyc(8, 1);
    cyc(9, 2);
    cyc(0, 0, 3'd6, 1);
    cyc(1, 0);
    chk("shl_res", K_BUS, 16'h0002);
    chk("shl_carry", K_CARRY, 1);
    cyc(0, 0, 3'd7, 1);
    cyc(1, 0);
    chk("shr_res", K_BUS, 16'h4000);
    chk("shr_carry", K_CARRY, 1);
    cyc(0, 0, 3'd2, 1);
    cyc(1, 0);
    chk("and_res", K_BUS, 16'h0000);
    chk("and_zero", K_ZERO, 1);
    chk("and_carry", K_CARRY, 0);
    cyc(0, 0, 3'd4, 1);
    cyc(1, 0);
    chk("xor_res", K_BUS, 16'h9235);
    chk("xor_zero", K_ZERO, 0);
    cyc(9, 1);
    cyc(0, 0, 3'd1, 1);
    cyc(1, 0);
    chk("sub_res", K_BUS, 16'h0000);
    chk("sub_zero", K_ZERO, 1);
    chk("sub_carry", K_CARRY, 1);

    port_in[W-1:0] = 16'hFFFF;
    cyc(8, 3);
    cyc(2, 0);
    chk("pc_load", K_BUS, 16'hFFFF);
    cyc(0, 0, 3'd0, 0, 1);
    cyc(2, 0);
    chk("pc_wrap", K_BUS, 16'h0000);
    port_in[W-1:0] = 16'h0040;
    cyc(8, 3, 3'd0, 0, 1);
    cyc(2, 10);
    chk("pc_dst_wins", K_BUS, 16'h0040);
    cyc(4, 0);
    chk("pout0", K_POUT0, 16'h0040);
    chk("reg0_hold", K_BUS, 16'h0005);

    port_in[W-1:0] = 16'h0010;
    mem_rdata = 16'hBEEF;
    cyc(8, 4);
    cyc(0, 0, 3'd0, 0, 0, 1);
    cyc(0, 0);
    chk("rd_req", K_REQ, 1);
    chk("rd_busy", K_BUSY, 1);
    chk("rd_we", K_WE, 0);
    chk("rd_addr", K_ADDR, 16'h0010);
    cyc(0, 4);
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 1);
    chk("mar_locked", K_ADDR, 16'h0010);
    ev("rd_done", 0, 16'hBEEF);
    cyc(0, 0);
    chk("done_busy", K_BUSY, 0);
    cyc(0, 0);
    chk("post_done", K_DONE, 0);
    chk("post_busy", K_BUSY, 0);

    cyc(0, 0, 3'd0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0);
      if (i == 1) chk("wr_we", K_WE, 1);
      if (i == 8) chk("wr_busy_last", K_BUSY, 1);
    end
    ev("timeout", 1, 16'hBEEF);
    cyc(0, 0);
    chk("to_idle", K_BUSY, 0);
    cyc(0, 0);
    chk("to_err_once", K_ERR, 0);

    cyc(0, 0, 3'd0, 0, 0, 1, 1);
    ev("both_cmd", 1, 16'hBEEF);
    cyc(0, 0);
    chk("both_req", K_REQ, 0);
    chk("both_busy", K_BUSY, 0);
    cyc(0, 0);

    cyc(0, 0, 3'd0, 0, 0, 1);
    cyc(1, 0);
    chk("pre_rst_busy", K_BUSY, 1);
    cyc(1, 0);
    rst = 1'b0;
    chk("arst_req", K_REQ, 0);
    chk("arst_busy", K_BUSY, 0);
    chk("arst_mar", K_ADDR, 0);
    chk("arst_mdr", K_WDATA, 0);
    chk("arst_aluout", K_BUS, 0);
    chk("arst_zero", K_ZERO, 0);
    chk("arst_carry", K_CARRY, 0);
    chk("arst_pout", K_POUT0, 0);
    cyc(2, 0, 3'd0, 0, 0, 0, 0, 1);
    chk("arst_pc", K_BUS, 0);
    rst = 1'b1;
    cyc(4, 0, 3'd0, 0, 0, 0, 0, 1);
    chk("arst_reg0", K_BUS, 0);
    chk("ack_ign_busy", K_BUSY, 0);
    chk("ack_ign_done", K_DONE, 0);
    cyc(5, 0, 3'd0, 0, 0, 0, 0, 1);
    chk("arst_reg1", K_BUS, 0);
    chk("ack_ign_mdr", K_WDATA, 0);
    cyc(0, 0);
    cyc(0, 0);
    fin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
